// File: rtl/conv_layer_ctrl_if.sv
// Control handshake, engine handshakes and shared scratch-port signals of conv_layer_ctrl.
// master = host/engine side, slave = the sequencer.
interface conv_layer_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;

  logic                  im2col_rst_n;
  logic                  im2col_done;
  logic [ADDR_WIDTH-1:0] im2col_addr_rd;
  logic [ADDR_WIDTH-1:0] im2col_addr_wr;
  logic [DATA_WIDTH-1:0] im2col_data_wr;
  logic                  im2col_wr_en;

  logic                  gemm_start;
  logic                  gemm_done;
  logic [ADDR_WIDTH-1:0] gemm_addr_rd;
  logic [ADDR_WIDTH-1:0] gemm_addr_wr;
  logic [DATA_WIDTH-1:0] gemm_data_wr;
  logic                  gemm_wr_en;

  logic [ADDR_WIDTH-1:0] mem_addr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr_wr;
  logic [DATA_WIDTH-1:0] mem_data_wr;
  logic                  mem_wr_en;

  logic [CNT_WIDTH-1:0]  im2col_cycles;
  logic [CNT_WIDTH-1:0]  gemm_cycles;

  modport master (
    output start,
    output im2col_done, im2col_addr_rd, im2col_addr_wr, im2col_data_wr, im2col_wr_en,
    output gemm_done, gemm_addr_rd, gemm_addr_wr, gemm_data_wr, gemm_wr_en,
    input  busy, done, error, im2col_rst_n, gemm_start,
    input  mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wr_en,
    input  im2col_cycles, gemm_cycles
  );

  modport slave (
    input  start,
    input  im2col_done, im2col_addr_rd, im2col_addr_wr, im2col_data_wr, im2col_wr_en,
    input  gemm_done, gemm_addr_rd, gemm_addr_wr, gemm_data_wr, gemm_wr_en,
    output busy, done, error, im2col_rst_n, gemm_start,
    output mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wr_en,
    output im2col_cycles, gemm_cycles
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Convolution-layer sequencer: runs im2col, then GEMM, owning the shared scratch port.
// Define CONV_CTRL_TIMEOUT_EN for the per-phase watchdog and the ERROR state.
module conv_layer_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic              clk,
  input logic              rst,
  conv_layer_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_IM2COL_RUN,
    S_GEMM_START,
    S_GEMM_RUN,
    S_DONE
`ifdef CONV_CTRL_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IM2COL,
    OWN_GEMM
  } owner_t;

  state_t               state;
  owner_t               owner;
  logic                 busy_q;
  logic                 done_q;
  logic                 gemm_start_q;
  logic                 im2col_rst_n_q;
  logic                 im2col_first;
  logic [CNT_WIDTH-1:0] im2col_cnt;
  logic [CNT_WIDTH-1:0] gemm_cnt;

`ifdef CONV_CTRL_TIMEOUT_EN
  logic        error_q;
  logic [31:0] wdog;
  logic        wdog_expired;

  // Expires on the TIMEOUT_CYCLES-th cycle of the current phase.
  assign wdog_expired = (wdog == 32'(TIMEOUT_CYCLES - 1));
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner          <= OWN_NONE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      gemm_start_q   <= 1'b0;
      im2col_rst_n_q <= 1'b0;
      im2col_first   <= 1'b0;
      im2col_cnt     <= '0;
      gemm_cnt       <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
      error_q        <= 1'b0;
      wdog           <= '0;
`endif
    end else begin
      gemm_start_q <= 1'b0;
      unique case (state)
        S_IM2COL_RUN: begin
          im2col_cnt   <= sat_inc(im2col_cnt);
          im2col_first <= 1'b0;
          // A done seen in the first cycle is stale from before the engine left reset.
          if (!im2col_first && bus.im2col_done) begin
            state          <= S_GEMM_START;
            gemm_start_q   <= 1'b1;
            im2col_rst_n_q <= 1'b0;
            owner          <= OWN_GEMM;
`ifdef CONV_CTRL_TIMEOUT_EN
            wdog           <= '0;
`endif
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (wdog_expired) begin
            state          <= S_ERROR;
            error_q        <= 1'b1;
            busy_q         <= 1'b0;
            im2col_rst_n_q <= 1'b0;
            owner          <= OWN_NONE;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end

        S_GEMM_START: begin
          gemm_cnt <= sat_inc(gemm_cnt);
`ifdef CONV_CTRL_TIMEOUT_EN
          if (wdog_expired) begin
            state   <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            owner   <= OWN_NONE;
          end else begin
            state <= S_GEMM_RUN;
            wdog  <= wdog + 32'd1;
          end
`else
          state <= S_GEMM_RUN;
`endif
        end

        S_GEMM_RUN: begin
          gemm_cnt <= sat_inc(gemm_cnt);
          if (bus.gemm_done) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            owner  <= OWN_NONE;
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (wdog_expired) begin
            state   <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            owner   <= OWN_NONE;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end

        // IDLE, DONE and ERROR: only start is honoured.
        default: begin
          if (bus.start) begin
            state          <= S_IM2COL_RUN;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            im2col_rst_n_q <= 1'b1;
            owner          <= OWN_IM2COL;
            im2col_first   <= 1'b1;
            im2col_cnt     <= '0;
            gemm_cnt       <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
            error_q        <= 1'b0;
            wdog           <= '0;
`endif
          end
        end
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] mux_addr_rd;
  logic [ADDR_WIDTH-1:0] mux_addr_wr;
  logic [DATA_WIDTH-1:0] mux_data_wr;
  logic                  mux_wr_en;

  always_comb begin
    mux_addr_rd = '0;
    mux_addr_wr = '0;
    mux_data_wr = '0;
    mux_wr_en   = 1'b0;
    unique case (owner)
      OWN_IM2COL: begin
        mux_addr_rd = bus.im2col_addr_rd;
        mux_addr_wr = bus.im2col_addr_wr;
        mux_data_wr = bus.im2col_data_wr;
        mux_wr_en   = bus.im2col_wr_en;
      end
      OWN_GEMM: begin
        mux_addr_rd = bus.gemm_addr_rd;
        mux_addr_wr = bus.gemm_addr_wr;
        mux_data_wr = bus.gemm_data_wr;
        mux_wr_en   = bus.gemm_wr_en;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr_rd   = mux_addr_rd;
  assign bus.mem_addr_wr   = mux_addr_wr;
  assign bus.mem_data_wr   = mux_data_wr;
  assign bus.mem_wr_en     = mux_wr_en;

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.gemm_start    = gemm_start_q;
  assign bus.im2col_rst_n  = im2col_rst_n_q;
  assign bus.im2col_cycles = im2col_cnt;
  assign bus.gemm_cycles   = gemm_cnt;
`ifdef CONV_CTRL_TIMEOUT_EN
  assign bus.error         = error_q;
`else
  assign bus.error         = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl: directed scenarios plus randomized runs
// checked against a phase-interval model of the layer sequence.
module tb_conv_layer_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned MW = 2 * AW + DW + 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  conv_layer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  conv_layer_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, error, gemm_start, im2col_rst_n}
  function automatic logic [4:0] ctl();
    return {bus.busy, bus.done, bus.error, bus.gemm_start, bus.im2col_rst_n};
  endfunction

  function automatic logic [MW-1:0] mem_out();
    return {bus.mem_addr_rd, bus.mem_addr_wr, bus.mem_data_wr, bus.mem_wr_en};
  endfunction

  function automatic logic [MW-1:0] im_in();
    return {bus.im2col_addr_rd, bus.im2col_addr_wr, bus.im2col_data_wr, bus.im2col_wr_en};
  endfunction

  function automatic logic [MW-1:0] gm_in();
    return {bus.gemm_addr_rd, bus.gemm_addr_wr, bus.gemm_data_wr, bus.gemm_wr_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic s, input logic id, input logic gd);
    bus.start       = s;
    bus.im2col_done = id;
    bus.gemm_done   = gd;
  endtask

  task automatic set_bus(input logic iwe, input logic gwe,
                         input logic [AW-1:0] iaw, input logic [AW-1:0] gaw);
    bus.im2col_wr_en   = iwe;
    bus.im2col_addr_wr = iaw;
    bus.im2col_addr_rd = $urandom;
    bus.im2col_data_wr = DW'($urandom);
    bus.gemm_wr_en     = gwe;
    bus.gemm_addr_wr   = gaw;
    bus.gemm_addr_rd   = $urandom;
    bus.gemm_data_wr   = DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b1);
    set_bus(1'b1, 1'b1, $urandom, $urandom);
    tick();
    tick();
    n_cmp++; if (ctl() !== 5'b0) begin n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 5'b0); end
    n_cmp++; if (mem_out() !== '0) begin n_err++; $display("FAIL reset_mem got=%h exp=0", mem_out()); end
    n_cmp++; if (bus.im2col_cycles !== '0 || bus.gemm_cycles !== '0) begin
      n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.im2col_cycles, bus.gemm_cycles);
    end
    rst = 1'b0;
    set_ctl(1'b0, 1'b1, 1'b1);
    set_bus(1'b1, 1'b1, $urandom, $urandom);
    tick();
    n_cmp++; if (ctl() !== 5'b0) begin n_err++; $display("FAIL idle_ctl got=%b exp=%b", ctl(), 5'b0); end
    n_cmp++; if (bus.mem_wr_en !== 1'b0 || mem_out() !== '0) begin
      n_err++; $display("FAIL idle_mem got=%h exp=0", mem_out());
    end
    set_ctl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nominal();
    logic [4:0] exp;
    for (int c = 0; c < 20; c++) begin
      set_ctl(c == 0, c >= 10, c == 16);
      set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      exp = {(c >= 1 && c <= 16), (c >= 17), 1'b0, (c == 11), (c >= 1 && c <= 10)};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL nominal_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      if (c == 17) begin
        n_cmp++; if (bus.im2col_cycles !== 32'd10) begin n_err++; $display("FAIL nominal_im2col_cycles got=%0d exp=10", bus.im2col_cycles); end
        n_cmp++; if (bus.gemm_cycles !== 32'd6) begin n_err++; $display("FAIL nominal_gemm_cycles got=%0d exp=6", bus.gemm_cycles); end
      end
      tick();
    end
  endtask

  task automatic test_stale_done();
    logic [4:0] exp;
    for (int c = 0; c < 8; c++) begin
      set_ctl(c == 0, 1'b1, c >= 3);
      set_bus(1'b0, 1'b0, $urandom, $urandom);
      #1;
      exp = {(c >= 1 && c <= 4), (c == 0 || c >= 5), 1'b0, (c == 3), (c >= 1 && c <= 2)};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL stale_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      if (c == 5) begin
        n_cmp++; if (bus.im2col_cycles !== 32'd2) begin n_err++; $display("FAIL stale_im2col_cycles got=%0d exp=2", bus.im2col_cycles); end
        n_cmp++; if (bus.gemm_cycles !== 32'd2) begin n_err++; $display("FAIL stale_gemm_cycles got=%0d exp=2", bus.gemm_cycles); end
      end
      tick();
    end
  endtask

  task automatic test_mux_isolation();
    logic [MW-1:0] exp;
    for (int c = 0; c < 12; c++) begin
      set_ctl(c == 0, c == 4, c == 8);
      if (c >= 1 && c <= 4)
        set_bus(c[0], 1'b1, 32'hA0 + 32'(c), 32'h55);
      else if (c >= 5 && c <= 8)
        set_bus(1'b1, c[0], 32'h55, 32'h30 + 32'(c));
      else
        set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      if (c >= 1 && c <= 4)      exp = im_in();
      else if (c >= 5 && c <= 8) exp = gm_in();
      else                       exp = '0;
      n_cmp++; if (mem_out() !== exp) begin n_err++; $display("FAIL mux_mem c=%0d got=%h exp=%h", c, mem_out(), exp); end
      tick();
    end
  endtask

  task automatic test_restart();
    logic [4:0] exp;
    for (int c = 0; c < 19; c++) begin
      set_ctl(c == 0 || c == 6 || c == 10, c == 3 || c == 13, c == 8 || c == 15);
      set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      exp = {((c >= 1 && c <= 8) || (c >= 11 && c <= 15)),
             (c == 0 || (c >= 9 && c <= 10) || c >= 16),
             1'b0,
             (c == 4 || c == 14),
             ((c >= 1 && c <= 3) || (c >= 11 && c <= 13))};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL restart_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      if (c == 9) begin
        n_cmp++; if (bus.im2col_cycles !== 32'd3 || bus.gemm_cycles !== 32'd5) begin
          n_err++; $display("FAIL restart_cnt_run1 got=%0d/%0d exp=3/5", bus.im2col_cycles, bus.gemm_cycles);
        end
      end
      if (c == 11) begin
        n_cmp++; if (bus.im2col_cycles !== 32'd0 || bus.gemm_cycles !== 32'd0) begin
          n_err++; $display("FAIL restart_cnt_clear got=%0d/%0d exp=0/0", bus.im2col_cycles, bus.gemm_cycles);
        end
      end
      if (c == 16) begin
        n_cmp++; if (bus.im2col_cycles !== 32'd3 || bus.gemm_cycles !== 32'd2) begin
          n_err++; $display("FAIL restart_cnt_run2 got=%0d/%0d exp=3/2", bus.im2col_cycles, bus.gemm_cycles);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] exp;
    for (int c = 0; c < 10; c++) begin
      rst = (c == 6);
      set_ctl(c == 0, c == 2, 1'b0);
      set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      exp = {(c >= 1 && c <= 6), (c == 0), 1'b0, (c == 3), (c >= 1 && c <= 2)};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL rstmid_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      if (c >= 7) begin
        n_cmp++; if (mem_out() !== '0) begin n_err++; $display("FAIL rstmid_mem c=%0d got=%h exp=0", c, mem_out()); end
        n_cmp++; if (bus.im2col_cycles !== '0 || bus.gemm_cycles !== '0) begin
          n_err++; $display("FAIL rstmid_cnt c=%0d got=%0d/%0d exp=0/0", c, bus.im2col_cycles, bus.gemm_cycles);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef CONV_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] exp;
    for (int c = 0; c < 31; c++) begin
      set_ctl(c == 0 || c == 21, c == 2 || c == 24, c == 27);
      set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      exp = {((c >= 1 && c <= 18) || (c >= 22 && c <= 27)),
             (c >= 28),
             (c >= 19 && c <= 21),
             (c == 3 || c == 25),
             ((c >= 1 && c <= 2) || (c >= 22 && c <= 24))};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL timeout_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      if (c == 19 || c == 21) begin
        n_cmp++; if (bus.gemm_cycles !== 32'd16 || bus.im2col_cycles !== 32'd2) begin
          n_err++; $display("FAIL timeout_cnt c=%0d got=%0d/%0d exp=2/16", c, bus.im2col_cycles, bus.gemm_cycles);
        end
        n_cmp++; if (mem_out() !== '0) begin n_err++; $display("FAIL timeout_mem c=%0d got=%h exp=0", c, mem_out()); end
      end
      if (c == 22) begin
        n_cmp++; if (bus.gemm_cycles !== '0 || bus.im2col_cycles !== '0) begin
          n_err++; $display("FAIL timeout_restart_cnt got=%0d/%0d exp=0/0", bus.im2col_cycles, bus.gemm_cycles);
        end
      end
      tick();
    end
  endtask
`else
  task automatic test_timeout();
    logic [4:0] exp;
    for (int c = 0; c < 40; c++) begin
      set_ctl(c == 0, c == 2, 1'b0);
      set_bus(1'b1, 1'b1, $urandom, $urandom);
      #1;
      exp = {(c >= 1), 1'b0, 1'b0, (c == 3), (c >= 1 && c <= 2)};
      n_cmp++; if (ctl() !== exp) begin n_err++; $display("FAIL nowdog_ctl c=%0d got=%b exp=%b", c, ctl(), exp); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ctl() !== 5'b0) begin n_err++; $display("FAIL nowdog_rst_ctl got=%b exp=%b", ctl(), 5'b0); end
  endtask
`endif

  // Each run: start at c=0, im2col phase on cycles 1..u, GEMM_START at u+1,
  // GEMM_RUN u+2..v, DONE from v+1. Done inputs are random wherever they must be ignored.
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int u;
      int v;
      u = int'($urandom_range(2, 12));
      v = u + 1 + int'($urandom_range(1, 11));
      for (int c = 0; c <= v + 2; c++) begin
        logic          in_im, in_gs, in_gr, in_dn;
        logic          id, gd, st;
        logic [4:0]    exp_ctl;
        logic [MW-1:0] exp_mem;
        int            exp_ic, exp_gc;
        in_im = (c >= 1) && (c <= u);
        in_gs = (c == u + 1);
        in_gr = (c >= u + 2) && (c <= v);
        in_dn = (c >= v + 1);
        if (c == u)                  id = 1'b1;
        else if (c <= 1 || c > u)    id = 1'($urandom);
        else                         id = 1'b0;
        if (c == v)                          gd = 1'b1;
        else if (c >= u + 2 && c < v)        gd = 1'b0;
        else                                 gd = 1'($urandom);
        if (c == 0)      st = 1'b1;
        else if (c <= v) st = 1'($urandom);
        else             st = 1'b0;
        set_ctl(st, id, gd);
        set_bus(1'($urandom), 1'($urandom), $urandom, $urandom);
        #1;
        if (c == 0) begin
          n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_pre it=%0d got=%b exp=0", it, bus.busy); end
        end else begin
          exp_ctl = {(in_im | in_gs | in_gr), in_dn, 1'b0, in_gs, in_im};
          n_cmp++; if (ctl() !== exp_ctl) begin
            n_err++; $display("FAIL rand_ctl it=%0d c=%0d u=%0d v=%0d got=%b exp=%b", it, c, u, v, ctl(), exp_ctl);
          end
          exp_ic = in_im ? c - 1 : u;
          exp_gc = in_im ? 0 : ((in_gs || in_gr) ? c - u - 1 : v - u);
          n_cmp++; if (bus.im2col_cycles !== CW'(exp_ic)) begin
            n_err++; $display("FAIL rand_im2col_cycles it=%0d c=%0d got=%0d exp=%0d", it, c, bus.im2col_cycles, exp_ic);
          end
          n_cmp++; if (bus.gemm_cycles !== CW'(exp_gc)) begin
            n_err++; $display("FAIL rand_gemm_cycles it=%0d c=%0d got=%0d exp=%0d", it, c, bus.gemm_cycles, exp_gc);
          end
        end
        if (in_im)               exp_mem = im_in();
        else if (in_gs || in_gr) exp_mem = gm_in();
        else                     exp_mem = '0;
        n_cmp++; if (mem_out() !== exp_mem) begin
          n_err++; $display("FAIL rand_mem it=%0d c=%0d got=%h exp=%h", it, c, mem_out(), exp_mem);
        end
        tick();
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    set_bus(1'b0, 1'b0, '0, '0);
    test_reset();
    test_nominal();
    test_stale_done();
    test_mux_isolation();
    test_restart();
    test_reset_midrun();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
